// File: rtl/multicycle_control.sv
// Multicycle RV32-subset control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory wait timeout and sticky trap causes. Optional JAL support via MULTICYCLE_CONTROL_JAL_EN.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       branch,
    output logic       jump,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_TRAP   = 4'd7,
        S_JUMP   = 4'd8
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // The wait that would bring the counter to MEM_TIMEOUT is the last one tolerated;
    // mem_ready in that same cycle still completes the access.
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] opcode_q;
    logic [7:0] wait_cnt;
    logic       illegal_q;
    logic       timeout_q;
    logic       set_illegal;
    logic       set_timeout;
    logic       wait_expired;

    function automatic logic is_load(input logic [6:0] op);
        return op == OP_LOAD;
    endfunction

    function automatic logic is_store(input logic [6:0] op);
        return op == OP_STORE;
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return is_load(op) || is_store(op);
    endfunction

    assign wait_expired = !mem_ready && (wait_cnt == LAST_WAIT);

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_b   = SRC_B_RS2;
        instr_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d     = S_TRAP;
                    set_timeout = 1'b1;
                end
            end

            S_DECODE: begin
                // ALU precomputes PC + imm so BRANCH has its target ready.
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE: state_d = S_EXEC;
                    OP_BRANCH:                     state_d = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_JAL_EN
                    OP_JAL:                        state_d = S_JUMP;
`endif
                    default: begin
                        state_d     = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end

            S_EXEC: begin
                alu_src_a = 1'b1;
                if (opcode_q == OP_R) begin
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_FUNCT;
                end else begin
                    alu_src_b = SRC_B_IMM;
                end
                state_d = is_mem_op(opcode_q) ? S_MEM : S_WB;
            end

            S_MEM: begin
                mem_read  = is_load(opcode_q);
                mem_write = is_store(opcode_q);
                if (mem_ready) begin
                    if (is_load(opcode_q)) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (wait_expired) begin
                    state_d     = S_TRAP;
                    set_timeout = 1'b1;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load(opcode_q);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_JUMP: begin
`ifdef MULTICYCLE_CONTROL_JAL_EN
                jump       = 1'b1;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
`else
                // Unreachable without JAL support; fail safe into the trap.
                state_d     = S_TRAP;
                set_illegal = 1'b1;
`endif
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opcode_q  <= 7'd0;
            wait_cnt  <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
            // Any state change clears the counter, which covers entry to FETCH and MEM.
            if (state_d != state_q) begin
                wait_cnt <= 8'd0;
            end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            illegal_q <= illegal_q | set_illegal;
            timeout_q <= timeout_q | set_timeout;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, each instruction class, memory waits,
// timeout boundary, illegal trap and asynchronous reset mid-access.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, ir_write, branch, jump, mem_read, mem_write;
    logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal, timeout;
    logic [1:0] alu_op, alu_src_b;
    logic [3:0] state;
    logic [13:0] ctl;

    int n_tests;
    int n_fail;
    int cyc_cnt;
    int t0;
    int rd_cycles;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    // {pc_write, ir_write, branch, jump, mem_read, mem_write, mem_to_reg, reg_write,
    //  alu_src_a, alu_op, alu_src_b, instr_done}
    localparam logic [13:0] C_ZERO   = 14'b0000_0000_0_00_00_0;
    localparam logic [13:0] C_F_RDY  = 14'b1100_1000_0_00_01_0;
    localparam logic [13:0] C_F_WAIT = 14'b0000_1000_0_00_01_0;
    localparam logic [13:0] C_DEC    = 14'b0000_0000_0_00_10_0;
    localparam logic [13:0] C_EX_R   = 14'b0000_0000_1_10_00_0;
    localparam logic [13:0] C_EX_I   = 14'b0000_0000_1_00_10_0;
    localparam logic [13:0] C_MEM_LD = 14'b0000_1000_0_00_00_0;
    localparam logic [13:0] C_MEM_ST = 14'b0000_0100_0_00_00_0;
    localparam logic [13:0] C_ST_DN  = 14'b0000_0100_0_00_00_1;
    localparam logic [13:0] C_WB_R   = 14'b0000_0001_0_00_00_1;
    localparam logic [13:0] C_WB_LD  = 14'b0000_0011_0_00_00_1;
    localparam logic [13:0] C_BRN    = 14'b0010_0000_1_01_00_1;
    localparam logic [13:0] C_JMP    = 14'b1001_0001_0_00_00_1;

    assign ctl = {pc_write, ir_write, branch, jump, mem_read, mem_write, mem_to_reg,
                  reg_write, alu_src_a, alu_op, alu_src_b, instr_done};

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .branch     (branch),
        .jump       (jump),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_op     (alu_op),
        .alu_src_b  (alu_src_b),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] st, input logic [13:0] c);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    endtask

    task automatic chk_flags(input string tag, input logic ill, input logic tmo);
        chk({tag, ".flags"}, 32'({illegal, timeout}), 32'({ill, tmo}));
    endtask

    // One clock cycle: inputs change just after the rising edge, outputs sampled at the falling edge.
    task automatic nc(input logic rdy, input logic [6:0] op);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        opcode    = op;
        cyc_cnt++;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc_cnt   = 0;
        rd_cycles = 0;
        rst_n     = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b0;

        nc(1'b1, BAD);
        nc(1'b1, BAD);
        chk_st("reset", 4'd0, C_ZERO);
        chk_flags("reset", 1'b0, 1'b0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_st("release", 4'd0, C_ZERO);

        // R-type, zero-wait memory; live opcode garbage after DECODE must not matter
        nc(1'b1, R);   chk_st("r.fetch", 4'd1, C_F_RDY);
        t0 = cyc_cnt;
        nc(1'b1, R);   chk_st("r.decode", 4'd2, C_DEC);
        nc(1'b1, BAD); chk_st("r.exec", 4'd3, C_EX_R);
        nc(1'b1, BAD); chk_st("r.wb", 4'd5, C_WB_R);
        nc(1'b1, LD);  chk_st("r.next", 4'd1, C_F_RDY);
        chk("r.latency", 32'(cyc_cnt - t0), 32'd4);

        // Load with three wait cycles in MEM
        t0 = cyc_cnt;
        nc(1'b1, LD);  chk_st("ld.decode", 4'd2, C_DEC);
        nc(1'b0, LD);  chk_st("ld.exec", 4'd3, C_EX_I);
        for (int i = 0; i < 3; i++) begin
            nc(1'b0, LD);
            chk_st("ld.mem_wait", 4'd4, C_MEM_LD);
            rd_cycles += mem_read;
        end
        nc(1'b1, LD);  chk_st("ld.mem_rdy", 4'd4, C_MEM_LD);
        rd_cycles += mem_read;
        chk("ld.read_cycles", 32'(rd_cycles), 32'd4);
        nc(1'b1, LD);  chk_st("ld.wb", 4'd5, C_WB_LD);
        nc(1'b1, ST);  chk_st("ld.next", 4'd1, C_F_RDY);
        chk("ld.latency", 32'(cyc_cnt - t0), 32'd8);

        // Store interrupted by reset in the middle of a MEM wait
        nc(1'b1, ST);  chk_st("st.decode", 4'd2, C_DEC);
        nc(1'b1, ST);  chk_st("st.exec", 4'd3, C_EX_I);
        nc(1'b0, ST);  chk_st("st.mem_wait", 4'd4, C_MEM_ST);
        nc(1'b0, ST);  chk_st("st.mem_wait2", 4'd4, C_MEM_ST);
        #2 rst_n = 1'b0;
        #1 chk_st("st.async_rst", 4'd0, C_ZERO);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_st("st.after_rst", 4'd0, C_ZERO);

        // Store with zero wait completes in four cycles
        nc(1'b1, ST);  chk_st("st2.fetch", 4'd1, C_F_RDY);
        t0 = cyc_cnt;
        nc(1'b1, ST);  chk_st("st2.decode", 4'd2, C_DEC);
        nc(1'b1, ST);  chk_st("st2.exec", 4'd3, C_EX_I);
        nc(1'b1, ST);  chk_st("st2.mem", 4'd4, C_ST_DN);
        nc(1'b1, BR);  chk_st("st2.next", 4'd1, C_F_RDY);
        chk("st2.latency", 32'(cyc_cnt - t0), 32'd4);

        // Branch
        nc(1'b1, BR);  chk_st("br.decode", 4'd2, C_DEC);
        nc(1'b1, BR);  chk_st("br.branch", 4'd6, C_BRN);
        nc(1'b1, JL);  chk_st("br.next", 4'd1, C_F_RDY);

        // JAL: jumps when enabled, otherwise an illegal-instruction trap
        nc(1'b1, JL);  chk_st("jal.decode", 4'd2, C_DEC);
        nc(1'b1, JL);
`ifdef MULTICYCLE_CONTROL_JAL_EN
        chk_st("jal.jump", 4'd8, C_JMP);
        chk_flags("jal.jump", 1'b0, 1'b0);
        nc(1'b1, R);   chk_st("jal.next", 4'd1, C_F_RDY);
`else
        chk_st("jal.trap", 4'd7, C_ZERO);
        chk_flags("jal.trap", 1'b1, 1'b0);
`endif
        reset_pulse();

        // Illegal opcode traps and stays put; mem_ready toggling is ignored
        nc(1'b1, BAD); chk_st("ill.fetch", 4'd1, C_F_RDY);
        nc(1'b1, BAD); chk_st("ill.decode", 4'd2, C_DEC);
        nc(1'b1, BAD); chk_st("ill.trap", 4'd7, C_ZERO);
        chk_flags("ill.trap", 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) nc(1'(i & 1), R);
        chk_st("ill.hold", 4'd7, C_ZERO);
        chk_flags("ill.hold", 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_st("ill.rst", 4'd0, C_ZERO);
        chk_flags("ill.rst", 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Fetch timeout: no mem_ready, trap on the 15th edge after FETCH entry
        nc(1'b0, R);   chk_st("to.fetch", 4'd1, C_F_WAIT);
        for (int i = 1; i <= 14; i++) begin
            nc(1'b0, R);
            chk("to.wait.state", 32'(state), 32'd1);
        end
        nc(1'b0, R);   chk_st("to.trap", 4'd7, C_ZERO);
        chk_flags("to.trap", 1'b0, 1'b1);
        reset_pulse();
        chk_flags("to.rst", 1'b0, 1'b0);

        // Rerun: mem_ready in the cycle that would otherwise time out still succeeds
        nc(1'b0, LD);  chk_st("to2.fetch", 4'd1, C_F_WAIT);
        for (int i = 1; i <= 13; i++) nc(1'b0, LD);
        chk_st("to2.wait", 4'd1, C_F_WAIT);
        nc(1'b1, LD);  chk_st("to2.last", 4'd1, C_F_RDY);
        nc(1'b0, LD);  chk_st("to2.decode", 4'd2, C_DEC);
        chk_flags("to2.decode", 1'b0, 1'b0);

        // Memory-state timeout on a load
        nc(1'b0, LD);  chk_st("to3.exec", 4'd3, C_EX_I);
        nc(1'b0, LD);  chk_st("to3.mem", 4'd4, C_MEM_LD);
        for (int i = 1; i <= 14; i++) nc(1'b0, LD);
        chk_st("to3.wait", 4'd4, C_MEM_LD);
        nc(1'b0, LD);  chk_st("to3.trap", 4'd7, C_ZERO);
        chk_flags("to3.trap", 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles to wait for mem_ready in any memory state; legal range 1..255.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 opcode  input  7  instr[6:0] from instruction register; valid from DECODE onward.
REQ-005 mem_ready  input  1  memory completion strobe for the current request.
REQ-006 pc_write, ir_write, branch, jump, mem_read, mem_write, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-007 alu_op  output  2  00 add, 01 subtract/compare, 10 funct-decoded.
REQ-008 alu_src_b  output  2  00 rs2, 01 constant 4, 10 immediate.
REQ-009 state  output  4  current state encoding.
REQ-010 instr_done  output  1  one-cycle pulse on the last cycle of each retired instruction.
REQ-011 illegal, timeout  output  1 each  sticky trap cause flags.

Function
REQ-012 States and encodings SHALL be: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, BRANCH 6, TRAP 7, JUMP 8.
REQ-013 Unlisted outputs SHALL be 0 in every state; IDLE drives all outputs 0 and moves to FETCH on the next edge.
REQ-014 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready (combinational); on mem_ready -> DECODE.
REQ-015 DECODE SHALL latch opcode into an internal register and drive alu_src_a=0, alu_src_b=10, alu_op=00 for the branch target.
REQ-016 DECODE next state: 0110011/0010011/0000011/0100011 -> EXEC; 1100011 -> BRANCH; 1101111 -> JUMP (macro-dependent); any other -> TRAP with illegal set.
REQ-017 EXEC: alu_src_a=1; R-type alu_src_b=00, alu_op=10; all others alu_src_b=10, alu_op=00; load/store -> MEM, R/I -> WB.
REQ-018 MEM: mem_read=1 for a load, mem_write=1 for a store, held until mem_ready; load -> WB, store -> FETCH with instr_done=1.
REQ-019 WB: reg_write=1, mem_to_reg=1 only for a load, instr_done=1; -> FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, instr_done=1; -> FETCH.
REQ-021 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without mem_ready; if it reaches MEM_TIMEOUT, -> TRAP with timeout set.
REQ-022 mem_ready arriving on the same cycle the counter reaches MEM_TIMEOUT SHALL count as success, with no trap.
REQ-023 mem_ready in non-memory states SHALL be ignored.
REQ-024 TRAP: all controls 0; illegal/timeout held; remains in TRAP until reset.
REQ-025 Minimum latency SHALL be R/I 4 cycles, load 5, store 4, branch 3, jump 3, counted from FETCH entry with zero-wait memory.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, all outputs 0, illegal=timeout=0, counter 0, latched opcode 0, including mid-instruction or mid-wait.
REQ-027 After rst_n rises, the first FETCH SHALL begin one edge later.

Configuration
REQ-028 Macro MULTICYCLE_CONTROL_JAL_EN defined: opcode 1101111 -> JUMP, driving jump=1, pc_write=1, reg_write=1, instr_done=1, then -> FETCH.
REQ-029 Macro undefined: JUMP unreachable, 1101111 traps as illegal, jump output tied 0.

Verification
REQ-030 Reset release, opcode 0110011, mem_ready=1 always -> states 1,2,3,5,1; reg_write=1 only in WB; instr_done pulse at cycle 4.
REQ-031 Load 0000011, mem_ready low 3 cycles in MEM -> mem_read held 4 cycles; WB with mem_to_reg=1; total 8 cycles.
REQ-032 Opcode 1111111 -> TRAP after DECODE, illegal=1, stays after 20 cycles; rst_n pulse -> IDLE, illegal=0.
REQ-033 FETCH with mem_ready never asserted, MEM_TIMEOUT=15 -> TRAP on edge 15, timeout=1; mem_ready exactly at count 15 in a rerun -> DECODE, no trap.
REQ-034 Opcode 1101111 -> JUMP with pc_write=reg_write=jump=1 when macro defined; TRAP with illegal=1 when undefined.
REQ-035 rst_n dropped mid-MEM of a store -> mem_write falls to 0 asynchronously, state 0, no write completes.
